// File: rtl/claa_cmp_decode_unit.sv
// Registered utility slice: one-hot tree decoder, two-level carry-lookahead adder and
// tree magnitude comparator behind one output register. Define CLAA_SIGNED_OVF_EN to add the ovf output.
module claa_cmp_decode_unit #(
   parameter int DEC_WIDTH    = 12,
   parameter int ADD_WIDTH    = 16,
   parameter int CASCADE_SIZE = 4,
   parameter int CMP_WIDTH    = 7
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         in_valid,
   input  logic [$clog2(DEC_WIDTH)-1:0] dec_sel,
   input  logic [ADD_WIDTH-1:0]         add_a,
   input  logic [ADD_WIDTH-1:0]         add_b,
   input  logic                         add_cin,
   input  logic [CMP_WIDTH-1:0]         cmp_a,
   input  logic [CMP_WIDTH-1:0]         cmp_b,
   output logic                         out_valid,
   output logic [DEC_WIDTH-1:0]         dec_out,
   output logic [ADD_WIDTH-1:0]         sum,
   output logic                         cout,
   output logic                         cmp_gt,
   output logic                         cmp_eq,
`ifdef CLAA_SIGNED_OVF_EN
   output logic                         ovf,
`endif
   output logic                         cmp_lt
);

   localparam int SEL_W  = $clog2(DEC_WIDTH);
   localparam int NG     = ADD_WIDTH / CASCADE_SIZE;
   localparam int CMP_P2 = 1 << $clog2(CMP_WIDTH);

   // Decoder tree: level l splits on select bit SEL_W-l; nodes whose whole subtree lies
   // beyond DEC_WIDTH are never built, so out-of-range selects fall through to all zero.
   logic [DEC_WIDTH-1:0] dec_comb;

   for (genvar l = 0; l <= SEL_W; l++) begin : g_lvl
      localparam int SPAN = 1 << (SEL_W - l);
      localparam int N    = (DEC_WIDTH + SPAN - 1) / SPAN;
      logic [N-1:0] node;
      if (l == 0) begin : g_root
         assign node = 1'b1;
      end else begin : g_split
         for (genvar j = 0; j < N; j++) begin : g_node
            if (j % 2 == 1) begin : g_hi
               assign node[j] = g_lvl[l-1].node[j/2] & dec_sel[SEL_W-l];
            end else begin : g_lo
               assign node[j] = g_lvl[l-1].node[j/2] & ~dec_sel[SEL_W-l];
            end
         end
      end
   end

   assign dec_comb = g_lvl[SEL_W].node;

   logic [ADD_WIDTH-1:0] bit_g, bit_p, pre_g, pre_p, carry, sum_comb;
   logic [NG-1:0]        grp_g, grp_p;
   logic [NG:0]          grp_c;

   assign bit_g = add_a & add_b;
   assign bit_p = add_a ^ add_b;

   // Every carry is a flat sum-of-products: in-group prefixes first, then the same
   // lookahead form over group G/P yields the group carry-ins.
   always_comb begin
      logic term;
      int   base;
      term  = 1'b0;
      base  = 0;
      pre_g = '0;
      pre_p = '0;
      grp_g = '0;
      grp_p = '0;
      grp_c = '0;
      carry = '0;
      for (int k = 0; k < NG; k++) begin
         base = k * CASCADE_SIZE;
         for (int i = 0; i < CASCADE_SIZE; i++) begin
            pre_p[base+i] = 1'b1;
            for (int m = 0; m <= i; m++) pre_p[base+i] = pre_p[base+i] & bit_p[base+m];
            for (int j = 0; j <= i; j++) begin
               term = bit_g[base+j];
               for (int m = j + 1; m <= i; m++) term = term & bit_p[base+m];
               pre_g[base+i] = pre_g[base+i] | term;
            end
         end
         grp_g[k] = pre_g[base+CASCADE_SIZE-1];
         grp_p[k] = pre_p[base+CASCADE_SIZE-1];
      end
      grp_c[0] = add_cin;
      for (int k = 0; k < NG; k++) begin
         term = add_cin;
         for (int m = 0; m <= k; m++) term = term & grp_p[m];
         grp_c[k+1] = term;
         for (int j = 0; j <= k; j++) begin
            term = grp_g[j];
            for (int m = j + 1; m <= k; m++) term = term & grp_p[m];
            grp_c[k+1] = grp_c[k+1] | term;
         end
      end
      for (int k = 0; k < NG; k++) begin
         base = k * CASCADE_SIZE;
         for (int i = 0; i < CASCADE_SIZE; i++) begin
            if (i == 0) carry[base] = grp_c[k];
            else        carry[base+i] = pre_g[base+i-1] | (pre_p[base+i-1] & grp_c[k]);
         end
      end
   end

   assign sum_comb = bit_p ^ carry;

   // Comparator operands are zero-padded to a power of two; heap node k has the
   // lower-order half at 2k+1 and the higher-order half at 2k+2.
   logic [CMP_P2-1:0]   pad_a, pad_b;
   logic [2*CMP_P2-2:0] node_gt, node_eq;

   always_comb begin
      pad_a   = CMP_P2'(cmp_a);
      pad_b   = CMP_P2'(cmp_b);
      node_gt = '0;
      node_eq = '0;
      for (int i = 0; i < CMP_P2; i++) begin
         node_gt[CMP_P2-1+i] = pad_a[i] & ~pad_b[i];
         node_eq[CMP_P2-1+i] = ~(pad_a[i] ^ pad_b[i]);
      end
      for (int k = CMP_P2 - 2; k >= 0; k--) begin
         node_gt[k] = node_gt[2*k+2] | (node_eq[2*k+2] & node_gt[2*k+1]);
         node_eq[k] = node_eq[2*k+2] & node_eq[2*k+1];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid <= 1'b0;
         dec_out   <= '0;
         sum       <= '0;
         cout      <= 1'b0;
         cmp_gt    <= 1'b0;
         cmp_eq    <= 1'b0;
         cmp_lt    <= 1'b0;
`ifdef CLAA_SIGNED_OVF_EN
         ovf       <= 1'b0;
`endif
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            dec_out <= dec_comb;
            sum     <= sum_comb;
            cout    <= grp_c[NG];
            cmp_gt  <= node_gt[0];
            cmp_eq  <= node_eq[0];
            cmp_lt  <= ~node_gt[0] & ~node_eq[0];
`ifdef CLAA_SIGNED_OVF_EN
            ovf     <= carry[ADD_WIDTH-1] ^ grp_c[NG];
`endif
         end
      end
   end

endmodule

// File: tb/tb_claa_cmp_decode_unit.sv
// Table-driven plus random scoreboard bench for claa_cmp_decode_unit (default parameters);
// the ovf output is checked only when CLAA_SIGNED_OVF_EN is defined.
module tb_claa_cmp_decode_unit;

   typedef struct {
      logic [3:0]  sel;
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic [6:0]  ca;
      logic [6:0]  cb;
      logic [11:0] dec;
      logic [15:0] sum;
      logic        cout;
      logic        gt;
      logic        eq;
      logic        lt;
      logic        ovf;
   } vec_t;

   localparam int NV = 9;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic [3:0]  dec_sel;
   logic [15:0] add_a, add_b;
   logic        add_cin;
   logic [6:0]  cmp_a, cmp_b;
   logic        out_valid;
   logic [11:0] dec_out;
   logic [15:0] sum;
   logic        cout, cmp_gt, cmp_eq, cmp_lt;
`ifdef CLAA_SIGNED_OVF_EN
   logic        ovf;
`endif

   int   n_cmp  = 0;
   int   n_fail = 0;
   vec_t tbl[NV];
   vec_t exp_q[$];

   claa_cmp_decode_unit dut (
      .clk      (clk),
      .reset    (reset),
      .in_valid (in_valid),
      .dec_sel  (dec_sel),
      .add_a    (add_a),
      .add_b    (add_b),
      .add_cin  (add_cin),
      .cmp_a    (cmp_a),
      .cmp_b    (cmp_b),
      .out_valid(out_valid),
      .dec_out  (dec_out),
      .sum      (sum),
      .cout     (cout),
      .cmp_gt   (cmp_gt),
      .cmp_eq   (cmp_eq),
`ifdef CLAA_SIGNED_OVF_EN
      .ovf      (ovf),
`endif
      .cmp_lt   (cmp_lt)
   );

   always #5 clk = ~clk;

   task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
      end
   endtask

   task automatic checkZero(input string name);
      checkVal({name, "_valid"}, 32'(out_valid), 0);
      checkVal({name, "_dec"},   32'(dec_out),   0);
      checkVal({name, "_sum"},   32'(sum),       0);
      checkVal({name, "_flags"}, 32'({cout, cmp_gt, cmp_eq, cmp_lt}), 0);
`ifdef CLAA_SIGNED_OVF_EN
      checkVal({name, "_ovf"},   32'(ovf),       0);
`endif
   endtask

   // Independent reference: wide addition, native unsigned compare, shift decode.
   function automatic vec_t model(input vec_t v);
      vec_t        r;
      logic [16:0] s;
      r      = v;
      s      = {1'b0, v.a} + {1'b0, v.b} + {16'b0, v.cin};
      r.sum  = s[15:0];
      r.cout = s[16];
      r.ovf  = (v.a[15] == v.b[15]) && (s[15] != v.a[15]);
      r.dec  = (v.sel < 4'd12) ? (12'd1 << v.sel) : 12'd0;
      r.gt   = v.ca > v.cb;
      r.eq   = v.ca == v.cb;
      r.lt   = v.ca < v.cb;
      return r;
   endfunction

   task automatic driveInputs(input vec_t v);
      dec_sel = v.sel;
      add_a   = v.a;
      add_b   = v.b;
      add_cin = v.cin;
      cmp_a   = v.ca;
      cmp_b   = v.cb;
   endtask

   task automatic applyStimulus(input vec_t v);
      @(negedge clk);
      driveInputs(v);
      in_valid = 1'b1;
      exp_q.push_back(v);
   endtask

   task automatic applyIdle();
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic checkOutput();
      vec_t e;
      if (exp_q.size() == 0) begin
         checkVal("unexpected_valid", 32'(out_valid), 0);
      end else begin
         e = exp_q.pop_front();
         checkVal("dec_out", 32'(dec_out), 32'(e.dec));
         checkVal("sum",     32'(sum),     32'(e.sum));
         checkVal("cout",    32'(cout),    32'(e.cout));
         checkVal("cmp_gt",  32'(cmp_gt),  32'(e.gt));
         checkVal("cmp_eq",  32'(cmp_eq),  32'(e.eq));
         checkVal("cmp_lt",  32'(cmp_lt),  32'(e.lt));
`ifdef CLAA_SIGNED_OVF_EN
         checkVal("ovf",     32'(ovf),     32'(e.ovf));
`endif
         checkVal("cmp_onehot", 32'($countones({cmp_gt, cmp_eq, cmp_lt})), 1);
         checkVal("dec_onehot", 32'($countones(dec_out)), (e.sel < 4'd12) ? 1 : 0);
      end
   endtask

   always @(negedge clk) begin
      if (!reset && out_valid) checkOutput();
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vec_t v;
      //          sel    a         b         cin   ca      cb      dec       sum       co    gt    eq    lt    ovf
      tbl[0] = '{4'd0,  16'd10,   16'd20,   1'b0, 7'd2,   7'd1,   12'h001, 16'd30,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[1] = '{4'd1,  16'hFFFF, 16'h0001, 1'b0, 7'd15,  7'd14,  12'h002, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[2] = '{4'd2,  16'h0FFF, 16'h0001, 1'b0, 7'd123, 7'd100, 12'h004, 16'h1000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[3] = '{4'd10, 16'h7FFF, 16'h0001, 1'b0, 7'd1,   7'd2,   12'h400, 16'h8000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      tbl[4] = '{4'd11, 16'h0000, 16'h0000, 1'b1, 7'd12,  7'd13,  12'h800, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[5] = '{4'd12, 16'h1234, 16'h4321, 1'b0, 7'd20,  7'd78,  12'h000, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[6] = '{4'd15, 16'h8000, 16'h8000, 1'b0, 7'd11,  7'd11,  12'h000, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      tbl[7] = '{4'd3,  16'hFFFF, 16'hFFFF, 1'b1, 7'd127, 7'd0,   12'h008, 16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[8] = '{4'd7,  16'h00FF, 16'h0F01, 1'b0, 7'd0,   7'd127, 12'h080, 16'h1000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

      reset    = 1'b1;
      in_valid = 1'b0;
      driveInputs(tbl[0]);
      repeat (2) @(negedge clk);
      checkZero("reset_hold");
      reset = 1'b0;
      repeat (3) @(negedge clk);
      checkZero("post_reset_idle");

      // Table vectors go in back to back, which also exercises streaming order.
      for (int i = 0; i < NV; i++) applyStimulus(tbl[i]);
      applyIdle();
      @(negedge clk);
      #1;
      checkVal("idle_valid", 32'(out_valid), 0);
      checkVal("hold_dec",   32'(dec_out),   32'(tbl[NV-1].dec));
      checkVal("hold_sum",   32'(sum),       32'(tbl[NV-1].sum));
      checkVal("hold_lt",    32'(cmp_lt),    32'(tbl[NV-1].lt));

      for (int n = 0; n < 1000; n++) begin
         if ($urandom_range(0, 7) == 0) applyIdle();
         v.sel = 4'($urandom_range(0, 15));
         v.a   = 16'($urandom_range(0, 65535));
         v.b   = 16'($urandom_range(0, 65535));
         v.cin = 1'($urandom_range(0, 1));
         v.ca  = 7'($urandom_range(0, 127));
         v.cb  = ($urandom_range(0, 7) == 0) ? v.ca : 7'($urandom_range(0, 127));
         applyStimulus(model(v));
      end
      applyIdle();
      for (int w = 0; w < 10 && exp_q.size() != 0; w++) @(negedge clk);
      checkVal("drain_empty", 32'(exp_q.size()), 0);

      // Mid-stream reset: outputs must clear between clock edges.
      @(negedge clk);
      driveInputs(tbl[7]);
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      checkVal("pre_reset_sum", 32'(sum), 32'(tbl[7].sum));
      #1;
      reset = 1'b1;
      #1;
      checkZero("async_reset");
      @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      checkZero("reset_release_idle");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
